// File: rtl/mdu_if.sv
// mdu_if: E-stage to MDU handshake and HI/LO result bundle.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, d_is_md, input busy, stall, hi, lo);
  modport slave  (input start, op, a, b, d_is_md, output busy, stall, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div timing model with HI/LO registers and pipeline stall.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave mdu
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d, plo_q, plo_d, hi_q, hi_d, lo_q, lo_d;
  logic sgn, neg_a, neg_b;
  logic [31:0] ma, mb, dv, uq, ur, quo, rem;
  logic [63:0] ea, eb, prod, res;
  // one datapath serves signed and unsigned forms; signed division works on magnitudes
  always_comb begin
    sgn = ~mdu.op[0];
    ea = {{32{sgn & mdu.a[31]}}, mdu.a};
    eb = {{32{sgn & mdu.b[31]}}, mdu.b};
    prod = ea * eb;
    neg_a = sgn & mdu.a[31];
    neg_b = sgn & mdu.b[31];
    ma = neg_a ? -mdu.a : mdu.a;
    mb = neg_b ? -mdu.b : mdu.b;
    dv = (mb == '0) ? 32'd1 : mb;
    uq = ma / dv;
    ur = ma % dv;
    quo = (neg_a ^ neg_b) ? -uq : uq;
    rem = neg_a ? -ur : ur;
    res = mdu.op[1] ? ((mb == '0) ? {hi_q, lo_q} : {rem, quo}) : prod;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    phi_d = phi_q;
    plo_d = plo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE) begin
      if (mdu.start && !mdu.op[2]) begin
        state_d = BUSY;
        cnt_d = mdu.op[1] ? DC : MC;
        {phi_d, plo_d} = res;
      end else if (mdu.start && mdu.op[2:1] == 2'b10) begin
        hi_d = mdu.op[0] ? hi_q : mdu.a;
        lo_d = mdu.op[0] ? mdu.a : lo_q;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign mdu.busy = (state_q == BUSY);
  assign mdu.stall = mdu.d_is_md & (mdu.busy | (mdu.start & ~mdu.op[2]));
  assign mdu.hi = hi_q;
  assign mdu.lo = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed checks of mdu_ctrl timing, arithmetic, stall and reset behaviour.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int passed = 0;
  mdu_if mdu ();
  mdu_ctrl dut (.clk(clk), .reset(reset), .mdu(mdu));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // start an op, check stall in the start cycle, busy/stall for n cycles, then the result
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ehi, input logic [31:0] elo);
    @(negedge clk);
    mdu.start = 1'b1; mdu.op = op; mdu.a = a; mdu.b = b;
    #1 chk("stall_start", {31'b0, mdu.stall}, {31'b0, mdu.d_is_md});
    @(negedge clk);
    mdu.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_hi", {31'b0, mdu.busy}, 32'd1);
      chk("stall_busy", {31'b0, mdu.stall}, {31'b0, mdu.d_is_md});
      @(negedge clk);
    end
    chk("busy_done", {31'b0, mdu.busy}, 32'd0);
    chk("stall_done", {31'b0, mdu.stall}, 32'd0);
    chk("hi", mdu.hi, ehi);
    chk("lo", mdu.lo, elo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    mdu.start = 1'b1; mdu.op = op; mdu.a = a;
    @(negedge clk);
    mdu.start = 1'b0;
    chk("mt_busy", {31'b0, mdu.busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mdu.start = 1'b0; mdu.op = 3'd0; mdu.a = '0; mdu.b = '0; mdu.d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'b0, mdu.busy}, 32'd0);
    chk("rst_hi", mdu.hi, 32'd0);
    chk("rst_lo", mdu.lo, 32'd0);
    chk("rst_stall", {31'b0, mdu.stall}, 32'd0);
    mdu.d_is_md = 1'b1;
    run_op(3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    mdu.d_is_md = 1'b0;
    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    mt(3'd4, 32'h11);
    chk("mthi_hi", mdu.hi, 32'h11);
    chk("mthi_lo", mdu.lo, 32'd3);
    mt(3'd5, 32'h22);
    chk("mtlo_lo", mdu.lo, 32'h22);
    chk("mtlo_hi", mdu.hi, 32'h11);
    run_op(3'd3, 32'd99, 32'd0, 10, 32'h11, 32'h22);
    mt(3'd4, 32'hDEADBEEF);
    chk("mthi_dead", mdu.hi, 32'hDEADBEEF);
    mdu.d_is_md = 1'b1;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
    mdu.d_is_md = 1'b0;
    // starts while busy (mthi and div) must not disturb the running mult
    @(negedge clk);
    mdu.start = 1'b1; mdu.op = 3'd0; mdu.a = 32'd3; mdu.b = 32'd4;
    @(negedge clk);
    mdu.op = 3'd4; mdu.a = 32'h55;
    chk("ign_busy1", {31'b0, mdu.busy}, 32'd1);
    @(negedge clk);
    mdu.op = 3'd2; mdu.a = 32'd100; mdu.b = 32'd7;
    chk("ign_busy2", {31'b0, mdu.busy}, 32'd1);
    chk("ign_hi_mid", mdu.hi, 32'd0);
    @(negedge clk);
    mdu.start = 1'b0;
    repeat (3) begin
      chk("ign_busy", {31'b0, mdu.busy}, 32'd1);
      @(negedge clk);
    end
    chk("ign_done", {31'b0, mdu.busy}, 32'd0);
    chk("ign_hi", mdu.hi, 32'd0);
    chk("ign_lo", mdu.lo, 32'd12);
    repeat (12) @(negedge clk);
    chk("ign_nobusy", {31'b0, mdu.busy}, 32'd0);
    chk("ign_lo_late", mdu.lo, 32'd12);
    mdu.start = 1'b1; mdu.op = 3'd6; mdu.a = 32'h77;
    @(negedge clk);
    mdu.op = 3'd7;
    @(negedge clk);
    mdu.start = 1'b0;
    chk("nop_busy", {31'b0, mdu.busy}, 32'd0);
    chk("nop_hi", mdu.hi, 32'd0);
    chk("nop_lo", mdu.lo, 32'd12);
    // reset in the third busy cycle of a div aborts it
    mdu.start = 1'b1; mdu.op = 3'd2; mdu.a = 32'd100; mdu.b = 32'd7;
    @(negedge clk);
    mdu.start = 1'b0;
    chk("abort_b1", {31'b0, mdu.busy}, 32'd1);
    @(negedge clk);
    chk("abort_b2", {31'b0, mdu.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'b0, mdu.busy}, 32'd0);
    chk("abort_hi", mdu.hi, 32'd0);
    chk("abort_lo", mdu.lo, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_hi_late", mdu.hi, 32'd0);
    chk("abort_lo_late", mdu.lo, 32'd0);
    reset = 1'b1; mdu.start = 1'b1; mdu.op = 3'd4; mdu.a = 32'h99;
    @(negedge clk);
    reset = 1'b0; mdu.start = 1'b0;
    chk("rprio_hi", mdu.hi, 32'd0);
    reset = 1'b1; mdu.start = 1'b1; mdu.op = 3'd0; mdu.a = 32'd5; mdu.b = 32'd5;
    @(negedge clk);
    reset = 1'b0; mdu.start = 1'b0;
    chk("rprio_busy", {31'b0, mdu.busy}, 32'd0);
    repeat (6) @(negedge clk);
    chk("rprio_lo", mdu.lo, 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
